regfile_op_sequencer: RTL and testbench

//  Initiator/client for the 16x16 two-read/one-write register file: accepts one
//  two-operand command over a valid/ready handshake, drives the read addresses,

---
 rtl/regfile_pkg.sv | 26 ++
 rtl/rf_alu.sv | 63 ++++++
 rtl/regfile_op_sequencer.sv | 124 ++++++++++++
 tb/tb_regfile_op_sequencer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file operation sequencer.
//   DATA_W / ADDR_W : register file data and address widths
//   Op*             : 3-bit command opcodes
//   state_e         : sequencer FSM state encoding
package regfile_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 4;

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpAnd = 3'b010;
    localparam logic [2:0] OpOr  = 3'b011;
    localparam logic [2:0] OpXor = 3'b100;
    localparam logic [2:0] OpShl = 3'b101;
    localparam logic [2:0] OpLdi = 3'b110;
    localparam logic [2:0] OpCmp = 3'b111;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StExec,
        StWrite
    } state_e;

endpackage

// File: rtl/rf_alu.sv
// Combinational ALU for the sequencer.
//   op_i        : opcode
//   a_i, b_i    : captured operands
//   imm_i       : immediate (LDI)
//   result_o    : result truncated to DATA_W (CMP: the difference, not written)
//   z_o/c_o/n_o : zero, carry/borrow/shifted-out bit, negative
module rf_alu
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = regfile_pkg::DATA_W
) (
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [DATA_W-1:0] imm_i,
    output logic [DATA_W-1:0] result_o,
    output logic              z_o,
    output logic              c_o,
    output logic              n_o
);

    localparam int unsigned ShW = $clog2(DATA_W);

    logic [DATA_W:0]  sum;
    logic [DATA_W:0]  diff;
    logic [DATA_W:0]  shl_ext;
    logic [ShW-1:0]   shamt;

    assign shamt = b_i[ShW-1:0];
    assign sum   = {1'b0, a_i} + {1'b0, b_i};
    // Top bit of the extended difference is the unsigned borrow (a < b).
    assign diff  = {1'b0, a_i} - {1'b0, b_i};
    // Top bit of the extended shift is the last bit shifted out; zero when shamt is 0.
    assign shl_ext = {1'b0, a_i} << shamt;

    always_comb begin
        result_o = '0;
        c_o      = 1'b0;
        unique case (op_i)
            OpAdd: begin
                result_o = sum[DATA_W-1:0];
                c_o      = sum[DATA_W];
            end
            OpSub, OpCmp: begin
                result_o = diff[DATA_W-1:0];
                c_o      = diff[DATA_W];
            end
            OpAnd: result_o = a_i & b_i;
            OpOr:  result_o = a_i | b_i;
            OpXor: result_o = a_i ^ b_i;
            OpShl: begin
                result_o = shl_ext[DATA_W-1:0];
                c_o      = shl_ext[DATA_W];
            end
            OpLdi: result_o = imm_i;
            default: ;
        endcase
    end

    assign z_o = (result_o == '0);
    assign n_o = result_o[DATA_W-1];

endmodule

// File: rtl/regfile_op_sequencer.sv
// Register-file client: accepts one two-operand command, reads both operands,
// executes the ALU op and writes the result back. One command per 4 cycles.
//   clk_i, rst_ni               : clock, async active-low reset
//   cmd_valid_i / cmd_ready_o   : command handshake (ready only in idle)
//   cmd_op/dst/src_a/src_b/imm_i: command fields, sampled at the accept edge
//   rf_read_addr_a/b_o          : register file read addresses
//   rf_read_data_a/b_i          : register file combinational read data
//   rf_write_en/addr/data_o     : register file write port
//   done_o                      : one-cycle retire pulse
//   flag_z/c/n_o                : flags of the last executed op
module regfile_op_sequencer
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = regfile_pkg::DATA_W,
    parameter int unsigned ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [2:0]        cmd_op_i,
    input  logic [ADDR_W-1:0] cmd_dst_i,
    input  logic [ADDR_W-1:0] cmd_src_a_i,
    input  logic [ADDR_W-1:0] cmd_src_b_i,
    input  logic [DATA_W-1:0] cmd_imm_i,
    output logic [ADDR_W-1:0] rf_read_addr_a_o,
    output logic [ADDR_W-1:0] rf_read_addr_b_o,
    input  logic [DATA_W-1:0] rf_read_data_a_i,
    input  logic [DATA_W-1:0] rf_read_data_b_i,
    output logic              rf_write_en_o,
    output logic [ADDR_W-1:0] rf_write_addr_o,
    output logic [DATA_W-1:0] rf_write_data_o,
    output logic              done_o,
    output logic              flag_z_o,
    output logic              flag_c_o,
    output logic              flag_n_o
);

    state_e            state_q;
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] dst_q;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] opa_q;
    logic [DATA_W-1:0] opb_q;

    logic [DATA_W-1:0] alu_result;
    logic              alu_z;
    logic              alu_c;
    logic              alu_n;

    rf_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op_i     (op_q),
        .a_i      (opa_q),
        .b_i      (opb_q),
        .imm_i    (imm_q),
        .result_o (alu_result),
        .z_o      (alu_z),
        .c_o      (alu_c),
        .n_o      (alu_n)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q          <= StIdle;
            op_q             <= '0;
            dst_q            <= '0;
            imm_q            <= '0;
            opa_q            <= '0;
            opb_q            <= '0;
            cmd_ready_o      <= 1'b1;
            rf_read_addr_a_o <= '0;
            rf_read_addr_b_o <= '0;
            rf_write_en_o    <= 1'b0;
            rf_write_addr_o  <= '0;
            rf_write_data_o  <= '0;
            done_o           <= 1'b0;
            flag_z_o         <= 1'b0;
            flag_c_o         <= 1'b0;
            flag_n_o         <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid_i) begin
                        op_q             <= cmd_op_i;
                        dst_q            <= cmd_dst_i;
                        imm_q            <= cmd_imm_i;
                        rf_read_addr_a_o <= cmd_src_a_i;
                        rf_read_addr_b_o <= cmd_src_b_i;
                        cmd_ready_o      <= 1'b0;
                        state_q          <= StRead;
                    end
                end
                StRead: begin
                    // Operands captured before any write-back, so dst==src sees the old value.
                    opa_q   <= rf_read_data_a_i;
                    opb_q   <= rf_read_data_b_i;
                    state_q <= StExec;
                end
                StExec: begin
                    flag_z_o <= alu_z;
                    flag_c_o <= alu_c;
                    flag_n_o <= alu_n;
                    done_o   <= 1'b1;
                    if (op_q != OpCmp) begin
                        rf_write_en_o   <= 1'b1;
                        rf_write_addr_o <= dst_q;
                        rf_write_data_o <= alu_result;
                    end
                    state_q <= StWrite;
                end
                StWrite: begin
                    rf_write_en_o <= 1'b0;
                    done_o        <= 1'b0;
                    cmd_ready_o   <= 1'b1;
                    state_q       <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_op_sequencer.sv
module tb_regfile_op_sequencer;
    import regfile_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [3:0]  cmd_dst;
    logic [3:0]  cmd_src_a;
    logic [3:0]  cmd_src_b;
    logic [15:0] cmd_imm;
    logic [3:0]  rf_read_addr_a;
    logic [3:0]  rf_read_addr_b;
    logic [15:0] rf_read_data_a;
    logic [15:0] rf_read_data_b;
    logic        rf_write_en;
    logic [3:0]  rf_write_addr;
    logic [15:0] rf_write_data;
    logic        done;
    logic        flag_z;
    logic        flag_c;
    logic        flag_n;

    int checks = 0;
    int errors = 0;
    int writes = 0;

    logic [15:0] rf [16];

    regfile_op_sequencer dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .cmd_valid_i      (cmd_valid),
        .cmd_ready_o      (cmd_ready),
        .cmd_op_i         (cmd_op),
        .cmd_dst_i        (cmd_dst),
        .cmd_src_a_i      (cmd_src_a),
        .cmd_src_b_i      (cmd_src_b),
        .cmd_imm_i        (cmd_imm),
        .rf_read_addr_a_o (rf_read_addr_a),
        .rf_read_addr_b_o (rf_read_addr_b),
        .rf_read_data_a_i (rf_read_data_a),
        .rf_read_data_b_i (rf_read_data_b),
        .rf_write_en_o    (rf_write_en),
        .rf_write_addr_o  (rf_write_addr),
        .rf_write_data_o  (rf_write_data),
        .done_o           (done),
        .flag_z_o         (flag_z),
        .flag_c_o         (flag_c),
        .flag_n_o         (flag_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural register file: combinational read, clocked write.
    assign rf_read_data_a = rf[rf_read_addr_a];
    assign rf_read_data_b = rf[rf_read_addr_b];

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = 16'h0000;
    end

    always @(posedge clk) begin
        if (rf_write_en) begin
            rf[rf_write_addr] <= rf_write_data;
            writes <= writes + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic check_flags(input string tag, input logic z, input logic c, input logic n);
        check(tag, {29'd0, flag_z, flag_c, flag_n}, {29'd0, z, c, n});
    endtask

    // Issue one command from an idle negedge and follow it through all four phases.
    task automatic run_cmd(input logic [2:0] op, input logic [3:0] dst, input logic [3:0] a,
                           input logic [3:0] b, input logic [15:0] imm);
        int n = 0;
        while (!cmd_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_dst   = dst;
        cmd_src_a = a;
        cmd_src_b = b;
        cmd_imm   = imm;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("read_busy", {31'd0, cmd_ready}, 32'd0);
        check("read_addr_a", {28'd0, rf_read_addr_a}, {28'd0, a});
        check("read_addr_b", {28'd0, rf_read_addr_b}, {28'd0, b});
        @(negedge clk);
        check("exec_no_write", {31'd0, rf_write_en}, 32'd0);
        @(negedge clk);
        check("write_en", {31'd0, rf_write_en}, {31'd0, op != OpCmp});
        check("done_high", {31'd0, done}, 32'd1);
        if (op != OpCmp) check("write_addr", {28'd0, rf_write_addr}, {28'd0, dst});
        @(negedge clk);
        check("done_pulse", {31'd0, done}, 32'd0);
        check("ready_back", {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        int k;
        int w0;
        logic rdy;

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_dst   = 4'd0;
        cmd_src_a = 4'd0;
        cmd_src_b = 4'd0;
        cmd_imm   = 16'd0;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_we", {31'd0, rf_write_en}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_wdata", {16'd0, rf_write_data}, 32'd0);
        check_flags("rst_flags", 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic LDI / ADD
        run_cmd(OpLdi, 4'd1, 4'd0, 4'd0, 16'h1234);
        check("r1_ldi", {16'd0, rf[1]}, 32'h1234);
        run_cmd(OpLdi, 4'd2, 4'd0, 4'd0, 16'h0001);
        run_cmd(OpAdd, 4'd3, 4'd1, 4'd2, 16'h0000);
        check("r3_add", {16'd0, rf[3]}, 32'h1235);
        check_flags("add_flags", 1'b0, 1'b0, 1'b0);

        // Carry and borrow
        run_cmd(OpLdi, 4'd4, 4'd0, 4'd0, 16'hFFFF);
        check_flags("ldi_neg_flags", 1'b0, 1'b0, 1'b1);
        run_cmd(OpAdd, 4'd5, 4'd4, 4'd2, 16'h0000);
        check("r5_wrap", {16'd0, rf[5]}, 32'h0000);
        check_flags("add_carry_flags", 1'b1, 1'b1, 1'b0);
        run_cmd(OpSub, 4'd6, 4'd2, 4'd4, 16'h0000);
        check("r6_sub", {16'd0, rf[6]}, 32'h0002);
        check_flags("sub_borrow_flags", 1'b0, 1'b1, 1'b0);

        // CMP writes nothing
        w0 = writes;
        run_cmd(OpCmp, 4'd1, 4'd1, 4'd1, 16'h0000);
        check("cmp_no_write", writes - w0, 32'd0);
        check_flags("cmp_flags", 1'b1, 1'b0, 1'b0);
        check("r1_after_cmp", {16'd0, rf[1]}, 32'h1234);

        // Shift and dst==src
        run_cmd(OpLdi, 4'd8, 4'd0, 4'd0, 16'h0004);
        run_cmd(OpShl, 4'd7, 4'd1, 4'd8, 16'h0000);
        check("r7_shl", {16'd0, rf[7]}, 32'h2340);
        check_flags("shl_flags", 1'b0, 1'b1, 1'b0);
        run_cmd(OpAnd, 4'd9, 4'd3, 4'd4, 16'h0000);
        check("r9_and", {16'd0, rf[9]}, 32'h1235);
        run_cmd(OpOr, 4'd10, 4'd2, 4'd7, 16'h0000);
        check("r10_or", {16'd0, rf[10]}, 32'h2341);
        run_cmd(OpSub, 4'd11, 4'd2, 4'd3, 16'h0000);
        check("r11_sub_neg", {16'd0, rf[11]}, 32'hEDCC);
        check_flags("sub_neg_flags", 1'b0, 1'b1, 1'b1);
        run_cmd(OpXor, 4'd1, 4'd1, 4'd1, 16'h0000);
        check("r1_xor_self", {16'd0, rf[1]}, 32'h0000);
        check_flags("xor_flags", 1'b1, 1'b0, 1'b0);

        // Reset in the middle of a write phase
        run_cmd(OpLdi, 4'd12, 4'd0, 4'd0, 16'h8000);
        cmd_valid = 1'b1;
        cmd_op    = OpLdi;
        cmd_dst   = 4'd10;
        cmd_imm   = 16'h5555;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_we", {31'd0, rf_write_en}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_we", {31'd0, rf_write_en}, 32'd0);
        check("midrst_ready", {31'd0, cmd_ready}, 32'd1);
        check("midrst_done", {31'd0, done}, 32'd0);
        check_flags("midrst_flags", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("r10_not_written", {16'd0, rf[10]}, 32'h2341);

        // Back-to-back: valid held high, next command presented as soon as one is taken
        w0 = writes;
        k = 0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i != 0) @(negedge clk);
            cmd_op  = OpLdi;
            cmd_dst = 4'(12 + k);
            cmd_imm = 16'hA000 + 16'(k);
            rdy = cmd_ready;
            check("b2b_ready_phase", {31'd0, rdy}, {31'd0, (i % 4) == 0});
            @(posedge clk);
            if (rdy) k++;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("b2b_accepts", k, 32'd4);
        check("b2b_writes", writes - w0, 32'd4);
        check("b2b_r12", {16'd0, rf[12]}, 32'hA000);
        check("b2b_r13", {16'd0, rf[13]}, 32'hA001);
        check("b2b_r14", {16'd0, rf[14]}, 32'hA002);
        check("b2b_r15", {16'd0, rf[15]}, 32'hA003);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
